mux_nto1_seq: RTL and testbench

MUX_NTO1_SEQ -- requirements
Module: mux_nto1_seq

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_nto1_comb.sv | 30 +++
 rtl/mux_nto1_seq.sv | 144 ++++++++++++++
 tb/tb_mux_nto1_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 sequential multiplexer.
// Holds the two-state FSM enum and the selector/counter width helper.
package mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_e;

    // Never returns zero, so a 1-element build still gets a legal vector width.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational element selector: out = vec[idx], or zero when idx is out of range.
module mux_nto1_comb
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_IN     = 4,
    parameter int IDX_W      = sel_width(NUM_IN)
) (
    input  logic [DATA_WIDTH-1:0] vec [NUM_IN-1:0],
    input  logic [IDX_W-1:0]      idx,
    output logic [DATA_WIDTH-1:0] out
);

    logic [NUM_IN-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_hit
            assign hit[gi] = (int'(idx) == gi);
        end
    endgenerate

    // One-hot AND-OR; no hit (index beyond NUM_IN-1) leaves the result zero.
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            out = out | (vec[i] & {DATA_WIDTH{hit[i]}});
        end
    end

endmodule

// File: rtl/mux_nto1_seq.sv
// N-to-1 registered mux with manual (single element) and serialise (whole vector burst) modes.
// Optional sticky out-of-range flag sel_err is built only when MUX_SEL_ERR_EN is defined.
module mux_nto1_seq
    import mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_IN     = 4,
    localparam int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] vec [NUM_IN-1:0],
    input  logic [SEL_W-1:0]      sel,
    input  logic                  auto_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef MUX_SEL_ERR_EN
    ,
    output logic                  sel_err
`endif
);

    localparam int CNT_W = sel_width(NUM_IN);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [NUM_IN-1:0];
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    logic [DATA_WIDTH-1:0] src [NUM_IN-1:0];
    logic [CNT_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] mux_out;
    logic                  load;
    logic                  accept;
    logic                  cnt_final;

    assign load      = !out_valid_q || out_ready;
    assign in_ready  = rst_n && (state_q == IDLE) && load;
    assign accept    = in_valid && in_ready;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign cnt_final = (cnt_q == CNT_W'(NUM_IN - 1));

    // One selector serves both modes: live inputs while idle, the captured copy while bursting.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            src[i] = (state_q == SERIAL) ? buf_q[i] : vec[i];
        end
        if (state_q == SERIAL) begin
            idx = cnt_q;
        end else if (auto_en) begin
            idx = '0;
        end else begin
            idx = CNT_W'(sel);
        end
    end

    mux_nto1_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN),
        .IDX_W      (CNT_W)
    ) u_sel (
        .vec (src),
        .idx (idx),
        .out (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_q       <= mux_out;
                        out_valid_q <= 1'b1;
                        if (auto_en) begin
                            buf_q <= vec;
                            if (NUM_IN == 1) begin
                                out_last_q <= 1'b1;
                            end else begin
                                out_last_q <= 1'b0;
                                cnt_q      <= CNT_W'(1);
                                state_q    <= SERIAL;
                            end
                        end else begin
                            out_last_q <= 1'b1;
                        end
                    end else if (load) begin
                        out_valid_q <= 1'b0;
                    end
                end
                SERIAL: begin
                    if (load) begin
                        out_q       <= mux_out;
                        out_valid_q <= 1'b1;
                        if (cnt_final) begin
                            out_last_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            out_last_q <= 1'b0;
                            cnt_q      <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef MUX_SEL_ERR_EN
    logic sel_err_q;
    logic sel_oob;

    assign sel_oob = (int'(sel) >= NUM_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (accept && !auto_en && sel_oob) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Self-checking bench for mux_nto1_seq: randomized traffic against a beat-queue reference model.
module tb_mux_nto1_seq;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int N3 = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] vec [N-1:0];
    logic [1:0]    sel;
    logic          auto_en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] vec3 [N3-1:0];
    logic [1:0]    sel3;
    logic          auto_en3;
    logic          in_valid3;
    logic          in_ready3;
    logic [DW-1:0] out3;
    logic          out_valid3;
    logic          out_ready3;
    logic          out_last3;

`ifdef MUX_SEL_ERR_EN
    logic sel_err;
    logic sel_err3;
`endif

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    logic  obs_in_ready;

    always #5 clk = ~clk;

    mux_nto1_seq #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec       (vec),
        .sel       (sel),
        .auto_en   (auto_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err)
`endif
    );

    mux_nto1_seq #(.DATA_WIDTH(DW), .NUM_IN(N3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec       (vec3),
        .sel       (sel3),
        .auto_en   (auto_en3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out       (out3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_last  (out_last3)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err3)
`endif
    );

    task automatic rand_vec();
        for (int i = 0; i < N; i++) vec[i] = DW'($urandom_range(0, 255));
    endtask

    // One clock: check the DUT against the model at the falling edge, then advance the model.
    // The model: outstanding beats sit in q; the head is what must be on the output,
    // and a new transfer may only be taken once nothing would remain after this edge.
    task automatic step();
        beat_t b;
        logic  exp_valid;
        logic  exp_ready;
        @(negedge clk);
        exp_valid = (q.size() > 0);
        exp_ready = rst_n && ((q.size() == 0) || (q.size() == 1 && out_ready));
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (out !== q[0].d || out_last !== q[0].last) begin
                errors++;
                $display("FAIL beat: got data=%h last=%b expected data=%h last=%b",
                         out, out_last, q[0].d, q[0].last);
            end
        end
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
        end
        obs_in_ready = in_ready;
        if (exp_valid && out_ready) b = q.pop_front();
        if (in_valid && exp_ready) begin
            if (auto_en) begin
                for (int i = 0; i < N; i++) begin
                    b.d    = vec[i];
                    b.last = (i == N - 1);
                    q.push_back(b);
                end
                $display("txn auto   vec=%h_%h_%h_%h", vec[3], vec[2], vec[1], vec[0]);
            end else begin
                b.d    = vec[sel];
                b.last = 1'b1;
                q.push_back(b);
                $display("txn manual sel=%0d data=%h", sel, vec[sel]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (q.size() > 0 && budget < 20) begin
            step();
            budget++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        auto_en   = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        rand_vec();
        in_valid3  = 1'b0;
        auto_en3   = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b1;
        for (int i = 0; i < N3; i++) vec3[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b last=%b out=%h in_ready=%b expected all 0",
                     out_valid, out_last, out, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_manual();
        vec[0] = 8'd1; vec[1] = 8'd2; vec[2] = 8'd3; vec[3] = 8'd4;
        sel = 2'd2; auto_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out !== 8'd3 || out_valid !== 1'b1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL manual_directed: got out=%h valid=%b last=%b expected out=03 valid=1 last=1",
                     out, out_valid, out_last);
        end
        for (int k = 0; k < 20; k++) begin
            rand_vec();
            sel      = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            step();
        end
        drain();
    endtask

    task automatic test_auto_burst();
        int not_ready;
        vec[0] = 8'h0A; vec[1] = 8'h0B; vec[2] = 8'h0C; vec[3] = 8'h0D;
        auto_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        not_ready = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (!obs_in_ready) not_ready++;
        end
        checks++;
        if (not_ready != 3) begin
            errors++;
            $display("FAIL auto_in_ready_low: got %0d cycles expected 3", not_ready);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        rand_vec();
        auto_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        held = out;
        repeat (5) step();
        checks++;
        if (out !== held) begin
            errors++;
            $display("FAIL backpressure_hold: got %h expected %h", out, held);
        end
        drain();
    endtask

    task automatic test_vec_change();
        rand_vec();
        auto_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_vec();
            sel     = 2'($urandom_range(0, 3));
            auto_en = 1'($urandom_range(0, 1));
            step();
        end
        drain();
    endtask

    task automatic test_range_error();
        logic [DW-1:0] exp_data;
        for (int i = 0; i < N3; i++) vec3[i] = DW'($urandom_range(1, 255));
        sel3 = 2'd3; auto_en3 = 1'b0; out_ready3 = 1'b1;
        checks++;
        if (in_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL range_in_ready: got %b expected 1", in_ready3);
        end
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        $display("txn manual3 sel=3 (out of range)");
        checks++;
        if (out3 !== '0 || out_valid3 !== 1'b1 || out_last3 !== 1'b1) begin
            errors++;
            $display("FAIL range_zero: got out=%h valid=%b last=%b expected out=00 valid=1 last=1",
                     out3, out_valid3, out_last3);
        end
`ifdef MUX_SEL_ERR_EN
        checks++;
        if (sel_err3 !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: got %b expected 1", sel_err3);
        end
`endif
        sel3      = 2'd1;
        exp_data  = vec3[1];
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        $display("txn manual3 sel=1 data=%h", exp_data);
        checks++;
        if (out3 !== exp_data || out_valid3 !== 1'b1 || out_last3 !== 1'b1) begin
            errors++;
            $display("FAIL range_legal_after: got out=%h valid=%b last=%b expected out=%h valid=1 last=1",
                     out3, out_valid3, out_last3, exp_data);
        end
`ifdef MUX_SEL_ERR_EN
        checks++;
        if (sel_err3 !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_sticky: got %b expected 1", sel_err3);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] first;
        rand_vec();
        auto_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: got valid=%b last=%b out=%h in_ready=%b expected all 0",
                     out_valid, out_last, out, in_ready);
        end
        q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst_release: got in_ready=%b valid=%b expected in_ready=1 valid=0",
                     in_ready, out_valid);
        end
        rand_vec();
        first    = vec[0];
        auto_en  = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out !== first || out_last !== 1'b0) begin
            errors++;
            $display("FAIL burst_restart: got out=%h last=%b expected out=%h last=0", out, out_last, first);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rand_vec();
            sel       = 2'($urandom_range(0, 3));
            auto_en   = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_burst();
        test_backpressure();
        test_vec_change();
        test_range_error();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
